// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, with a data-memory watchdog and a sticky TRAP state.
module stage_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instruction,
    input  logic        memReady,
    input  logic        branchCond,
    output logic        irWrite,
    output logic        pcWrite,
    output logic [1:0]  pcSrc,
    output logic        memReq,
    output logic        memWe,
    output logic        regWriteEn,
    output logic [2:0]  stage,
    output logic        illegal,
    output logic        memTimeout,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b111
    } state_t;

    localparam logic [2:0] CL_NOP   = 3'b000;
    localparam logic [2:0] CL_ALU   = 3'b001;
    localparam logic [2:0] CL_CONST = 3'b010;
    localparam logic [2:0] CL_LDST  = 3'b100;
    localparam logic [2:0] CL_CTRL  = 3'b101;

    localparam logic [2:0] SUB_JUMP = 3'b000;
    localparam logic [2:0] SUB_BEQ  = 3'b001;
    localparam logic [2:0] SUB_BNE  = 3'b010;
    localparam logic [2:0] SUB_JAL  = 3'b011;
    localparam logic [2:0] SUB_JR   = 3'b100;

    state_t      state_q, state_d;
    logic [2:0]  class_q, class_d;
    logic [2:0]  sub_q, sub_d;
    logic        store_q, store_d;
    logic [3:0]  wdog_q, wdog_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic [15:0] retired_q, retired_d;

    logic        ir_w, pc_w, mem_req, mem_we, reg_we;
    logic [1:0]  pc_src;
    logic [2:0]  dec_class, dec_sub;
    logic        unused_instr_bits;

    assign dec_class         = instruction[31:29];
    assign dec_sub           = instruction[28:26];
    assign unused_instr_bits = ^{instruction[25], instruction[23:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            class_q   <= 3'b000;
            sub_q     <= 3'b000;
            store_q   <= 1'b0;
            wdog_q    <= 4'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            sub_q     <= sub_d;
            store_q   <= store_d;
            wdog_q    <= wdog_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        sub_d     = sub_q;
        store_d   = store_q;
        wdog_d    = wdog_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        ir_w      = 1'b0;
        pc_w      = 1'b0;
        pc_src    = 2'b00;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_w    = 1'b1;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                class_d = dec_class;
                sub_d   = (dec_class == CL_CTRL) ? dec_sub : 3'b000;
                store_d = (dec_class == CL_LDST) & instruction[24];
                case (dec_class)
                    CL_NOP: begin
                        pc_w    = 1'b1;
                        state_d = S_FETCH;
                    end
                    CL_ALU, CL_CONST, CL_LDST: state_d = S_EXEC;
                    CL_CTRL: begin
                        if (dec_sub <= SUB_JR) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            S_EXEC: begin
                case (class_q)
                    CL_ALU, CL_CONST: state_d = S_WB;
                    CL_LDST: begin
                        state_d = S_MEM;
                        wdog_d  = 4'd0;
                    end
                    CL_CTRL: begin
                        // Branches and jumps retire here; only jal needs a writeback.
                        case (sub_q)
                            SUB_JUMP: begin
                                pc_w    = 1'b1;
                                pc_src  = 2'b01;
                                state_d = S_FETCH;
                            end
                            SUB_BEQ, SUB_BNE: begin
                                pc_w    = 1'b1;
                                pc_src  = branchCond ? 2'b01 : 2'b00;
                                state_d = S_FETCH;
                            end
                            SUB_JR: begin
                                pc_w    = 1'b1;
                                pc_src  = 2'b10;
                                state_d = S_FETCH;
                            end
                            SUB_JAL: state_d = S_WB;
                            default: state_d = S_TRAP;
                        endcase
                    end
                    default: state_d = S_TRAP;
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = store_q;
                if (memReady) begin
                    if (store_q) begin
                        pc_w    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wdog_q == 4'hF) begin
                    // Sixteenth consecutive stalled cycle: give up on the access.
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 4'd1;
                end
            end

            S_WB: begin
                reg_we  = 1'b1;
                pc_w    = 1'b1;
                pc_src  = (class_q == CL_CTRL) ? 2'b01 : 2'b00;
                state_d = S_FETCH;
            end

            S_TRAP: state_d = S_TRAP;

            default: state_d = S_TRAP;
        endcase

        retired_d = pc_w ? retired_q + 16'd1 : retired_q;
    end

    // Strobes are gated by reset_n so they drop the moment reset asserts.
    assign irWrite    = ir_w & reset_n;
    assign pcWrite    = pc_w & reset_n;
    assign pcSrc      = reset_n ? pc_src : 2'b00;
    assign memReq     = mem_req & reset_n;
    assign memWe      = mem_we & reset_n;
    assign regWriteEn = reg_we & reset_n;
    assign stage      = state_q;
    assign illegal    = illegal_q;
    assign memTimeout = timeout_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: per-cycle expected outputs are queued
// as each step is set up and popped/compared while the DUT executes it.
module tb_stage_sequencer;

    logic        clock;
    logic        reset_n;
    logic [31:0] instruction;
    logic        memReady;
    logic        branchCond;
    logic        irWrite;
    logic        pcWrite;
    logic [1:0]  pcSrc;
    logic        memReq;
    logic        memWe;
    logic        regWriteEn;
    logic [2:0]  stage;
    logic        illegal;
    logic        memTimeout;
    logic [15:0] retired;

    stage_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instruction (instruction),
        .memReady    (memReady),
        .branchCond  (branchCond),
        .irWrite     (irWrite),
        .pcWrite     (pcWrite),
        .pcSrc       (pcSrc),
        .memReq      (memReq),
        .memWe       (memWe),
        .regWriteEn  (regWriteEn),
        .stage       (stage),
        .illegal     (illegal),
        .memTimeout  (memTimeout),
        .retired     (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_retired = 16'd0;

    // Expected vector: {stage, irWrite, pcWrite, pcSrc, memReq, memWe, regWriteEn}
    task automatic ex(input string tag, input logic [2:0] st, input logic ir, input logic pw,
                      input logic [1:0] src, input logic mr, input logic mw, input logic rw);
        exp_t e;
        e.tag = tag;
        e.v   = {st, ir, pw, src, mr, mw, rw};
        sb_q.push_back(e);
        if (pw) exp_retired = exp_retired + 16'd1;
    endtask

    task automatic check_out();
        logic [9:0] obs;
        exp_t       e;
        obs = {stage, irWrite, pcWrite, pcSrc, memReq, memWe, regWriteEn};
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_underflow: observed %b required an expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.v) else begin
                fails++;
                $error("FAIL %s: observed %b required %b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    // Drive inputs just after an edge, sample mid-cycle, then advance one clock.
    task automatic run_cycle(input logic mr, input logic bc);
        memReady   = mr;
        branchCond = bc;
        #2;
        check_out();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [31:0] ins);
        instruction = ins;
        ex({tag, "_fetch"}, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b1);
        ex({tag, "_decode"}, 3'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        exp_retired = 16'd0;
        ex({tag, "_outputs"}, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        check_out();
        check_val({tag, "_illegal"}, 32'(illegal), 32'd0);
        check_val({tag, "_timeout"}, 32'(memTimeout), 32'd0);
        check_val({tag, "_retired"}, 32'(retired), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        instruction = 32'h0;
        memReady    = 1'b0;
        branchCond  = 1'b0;
        #12;
        ex("reset_outputs", 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        check_out();
        check_val("reset_retired", 32'(retired), 32'd0);
        check_val("reset_flags", 32'({illegal, memTimeout}), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // ALU add, then constant: F, D, EXEC, WB
        fetch_decode("alu", 32'h2000_0000);
        ex("alu_exec", 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b1, 1'b1);
        ex("alu_wb", 3'd4, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);   run_cycle(1'b1, 1'b1);
        check_val("alu_retired", 32'(retired), 32'd1);
        fetch_decode("const", 32'h4000_0000);
        ex("const_exec", 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b0, 1'b0);
        ex("const_wb", 3'd4, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);   run_cycle(1'b0, 1'b0);

        // Load with three stall cycles
        fetch_decode("load", 32'h8000_0000);
        ex("load_exec", 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ex("load_mem_wait", 3'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0); run_cycle(1'b0, 1'b0);
        end
        ex("load_mem_ready", 3'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0); run_cycle(1'b1, 1'b0);
        ex("load_wb", 3'd4, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);      run_cycle(1'b0, 1'b0);
        check_val("load_retired", 32'(retired), 32'(exp_retired));

        // Control class: beq taken / not taken, bne, jump, jr, jal
        fetch_decode("beq_t", 32'hA400_0000);
        ex("beq_t_exec", 3'd2, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0); run_cycle(1'b1, 1'b1);
        fetch_decode("beq_n", 32'hA400_0000);
        ex("beq_n_exec", 3'd2, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b1, 1'b0);
        fetch_decode("bne_t", 32'hA800_0000);
        ex("bne_t_exec", 3'd2, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0); run_cycle(1'b0, 1'b1);
        fetch_decode("jump", 32'hA000_0000);
        ex("jump_exec", 3'd2, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);  run_cycle(1'b0, 1'b0);
        fetch_decode("jr", 32'hB000_0000);
        ex("jr_exec", 3'd2, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);    run_cycle(1'b0, 1'b1);
        fetch_decode("jal", 32'hAC00_0000);
        ex("jal_exec", 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);   run_cycle(1'b0, 1'b1);
        ex("jal_wb", 3'd4, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);     run_cycle(1'b0, 1'b0);
        check_val("ctrl_retired", 32'(retired), 32'(exp_retired));

        // NOP: two cycles, retires in DECODE
        instruction = 32'h0;
        ex("nop_fetch", 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);  run_cycle(1'b0, 1'b0);
        ex("nop_decode", 3'd1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b1, 1'b1);

        // Store completing immediately, then on the 16th MEM cycle
        fetch_decode("store", 32'h8100_0000);
        ex("store_exec", 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b1, 1'b0);
        ex("store_mem", 3'd3, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);  run_cycle(1'b1, 1'b0);
        fetch_decode("st16", 32'h8100_0000);
        ex("st16_exec", 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);  run_cycle(1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            ex("st16_mem_wait", 3'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0); run_cycle(1'b0, 1'b0);
        end
        ex("st16_mem_ready", 3'd3, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0); run_cycle(1'b1, 1'b0);
        ex("st16_next_fetch", 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        #2; check_out();
        check_val("st16_no_timeout", 32'(memTimeout), 32'd0);
        check_val("st16_retired", 32'(retired), 32'(exp_retired));

        // Store timeout: memReady stays low for 16 MEM cycles
        fetch_decode("sto", 32'h8100_0000);
        ex("sto_exec", 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            ex("sto_mem_wait", 3'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0); run_cycle(1'b0, 1'b0);
        end
        ex("sto_trap", 3'd7, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b1, 1'b1);
        check_val("sto_timeout", 32'(memTimeout), 32'd1);
        check_val("sto_illegal", 32'(illegal), 32'd0);
        check_val("sto_retired", 32'(retired), 32'(exp_retired));
        do_reset("sto_rst");

        // Undefined class: TRAP absorbs any input for 20 cycles
        fetch_decode("ill", 32'hE000_0000);
        for (int i = 0; i < 20; i++) begin
            instruction = $urandom;
            ex("ill_trap", 3'd7, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check_val("ill_flag", 32'(illegal), 32'd1);
        check_val("ill_retired", 32'(retired), 32'd0);
        do_reset("ill_rst");

        // Undefined control subcode 101
        fetch_decode("badsub", 32'hB400_0000);
        ex("badsub_trap", 3'd7, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b1, 1'b1);
        check_val("badsub_flag", 32'(illegal), 32'd1);
        do_reset("badsub_rst");

        // Retirement counter wrap: backdoor preload, then a NOP stream
        dut.retired_q = 16'hFFF0;
        exp_retired   = 16'hFFF0;
        instruction   = 32'h0;
        for (int i = 0; i < 16; i++) begin
            ex("wrap_fetch", 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);  run_cycle(1'b0, 1'b0);
            ex("wrap_decode", 3'd1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b0, 1'b0);
            if (i == 14) check_val("wrap_ffff", 32'(retired), 32'h0000_FFFF);
        end
        check_val("wrap_zero", 32'(retired), 32'h0000_0000);

        // Asynchronous reset in the middle of a MEM stall
        fetch_decode("midmem", 32'h8000_0000);
        ex("midmem_exec", 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b0, 1'b0);
        ex("midmem_mem", 3'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);  run_cycle(1'b0, 1'b0);
        #3;
        do_reset("midmem_rst");

        // Restart after reset goes straight into FETCH
        fetch_decode("restart", 32'h2000_0000);
        ex("restart_exec", 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); run_cycle(1'b0, 1'b0);
        ex("restart_wb", 3'd4, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);   run_cycle(1'b0, 1'b0);
        check_val("restart_retired", 32'(retired), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
